axi_lite_slave_mmap_4x32_r4: RTL and testbench
==============================================

Name: axi_lite_slave_mmap_4x32_r4

Overview:
- AXI4-Lite slave exposing four 32-bit read/write registers (reg0..reg3) at byte offsets 0x0, 0x4, 0x8 and 0xC.
- Used as a simple memory-mapped control/status register file behind an AXI-Lite interconnect.
- Supports byte-strobed writes; every response is OKAY.
- Read and write channels are independent.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width. Only 4 is supported; register index is addr[3:2].

Ports:
- S_AXI_ACLK  in  1  single clock; all logic on its rising edge.
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- S_AXI_AWADDR  in  4  write byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address accepted.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit i covers bits [8i+7:8i].
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data accepted.
- S_AXI_BRESP  out  2  write response, always 2'b00.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  master ready for the write response.
- S_AXI_ARADDR  in  4  read byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address accepted.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  master ready for read data.

Behaviour:
- Reset (ARESETN=0 at a rising edge):
  - reg0..reg3 = 0.
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; RDATA = 0.
  - Write-enable flag aw_en = 1.
  - Any in-flight transaction is abandoned with no response.
- Address decode: index = addr[3:2]; addr[1:0] ignored (0xF selects reg3). No decode errors; BRESP and RRESP are always 2'b00.
- Write path:
  - Cycle N: AWVALID=1, WVALID=1, AWREADY=0 and aw_en=1 sampled. AWREADY and WREADY go high together after edge N, for exactly one cycle. The captured address is latched.
  - Edge N+1 (both VALIDs and both READYs high):
    - Selected register updated byte-wise: bytes with WSTRB=1 take WDATA, others keep their value.
    - BVALID=1; AWREADY=WREADY=0; aw_en=0.
  - BVALID holds until BVALID&&BREADY at an edge, then clears and aw_en returns to 1.
  - No new write is accepted while aw_en=0, even if the master still holds VALIDs high.
  - AW alone or W alone is never accepted; both must be valid.
- Read path:
  - ARVALID=1, ARREADY=0 and RVALID=0 at an edge: ARREADY=1 for exactly one cycle; ARADDR is latched.
  - Edge with ARVALID&&ARREADY: RDATA captures the selected register, RVALID=1, ARREADY=0.
  - RDATA and RVALID hold stable until RVALID&&RREADY at an edge, then RVALID clears.
  - No new read is accepted while RVALID=1.
- Simultaneous read and write commit to the same register on the same edge: the read returns the pre-write value.
- Latency: write response 2 cycles after both VALIDs; read data 2 cycles after ARVALID.

Test Plan:
- After reset, read 0x0/0x4/0x8/0xC -> each 0x00000000 with RRESP=0.
- Full-strobe writes DEADBEEF@0x0, 12345678@0x4, ABCDEF01@0x8, 87654321@0xC -> read-back matches each; BRESP=0.
- Partial strobes:
  - 0x000000FF strb 0x1 @0x0 -> 0xDEADBEFF.
  - 0xAA000000 strb 0x8 @0x4 -> 0xAA345678.
  - 0x0000FFFF strb 0x6 @0x8 -> 0xAB00FF01.
- Unaligned write 0xFFFFFFFF @0xF -> reg3=0xFFFFFFFF; reg0..reg2 unchanged.
- Pulse ARESETN low 5 cycles after writes -> all four registers read 0.
- Master holds VALIDs one extra cycle after READY and delays BREADY/RREADY -> exactly one write/read accepted per transaction; BVALID/RVALID/RDATA stay stable until their ready.

Source files
------------

// File: rtl/axi_lite_slave_mmap_4x32_r4_if.sv
// rtl/axi_lite_slave_mmap_4x32_r4_if.sv - AXI4-Lite bus bundle for the 4x32 register slave
interface axi_lite_slave_mmap_4x32_r4_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                        awprot;
  logic                              awvalid;
  logic                              awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                              wvalid;
  logic                              wready;
  logic [1:0]                        bresp;
  logic                              bvalid;
  logic                              bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                        arprot;
  logic                              arvalid;
  logic                              arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                        rresp;
  logic                              rvalid;
  logic                              rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave_mmap_4x32_r4.sv
// rtl/axi_lite_slave_mmap_4x32_r4.sv - AXI4-Lite slave with four byte-strobed 32-bit registers
module axi_lite_slave_mmap_4x32_r4 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input logic                          S_AXI_ACLK,
  input logic                          S_AXI_ARESETN,
  axi_lite_slave_mmap_4x32_r4_if.slave s_axi
);
  localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic [1:0]                    aw_idx;
  logic [1:0]                    ar_idx;
  logic                          aw_en;
  logic                          wr_fire;
  logic                          rd_fire;
  logic                          unused_ok;

  assign wr_fire = s_axi.awready && s_axi.awvalid && s_axi.wready && s_axi.wvalid;
  assign rd_fire = s_axi.arready && s_axi.arvalid && !s_axi.rvalid;

  assign s_axi.bresp = 2'b00;
  assign s_axi.rresp = 2'b00;

  // Protection bits and the sub-word address bits carry no meaning here.
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                       s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Write address/data acceptance: both channels must be valid together,
  // and aw_en blocks a new accept until the previous response is taken.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      aw_idx        <= 2'd0;
    end else if (!s_axi.awready && s_axi.awvalid && s_axi.wvalid && aw_en) begin
      s_axi.awready <= 1'b1;
      s_axi.wready  <= 1'b1;
      aw_idx        <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1 -: 2];
    end else begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      s_axi.bvalid <= 1'b0;
      aw_en        <= 1'b1;
    end else if (wr_fire) begin
      s_axi.bvalid <= 1'b1;
      aw_en        <= 1'b0;
    end else if (s_axi.bvalid && s_axi.bready) begin
      s_axi.bvalid <= 1'b0;
      aw_en        <= 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int r = 0; r < 4; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_fire) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (s_axi.wstrb[b]) begin
          regs[aw_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      s_axi.arready <= 1'b0;
      ar_idx        <= 2'd0;
    end else if (!s_axi.arready && s_axi.arvalid && !s_axi.rvalid) begin
      s_axi.arready <= 1'b1;
      ar_idx        <= s_axi.araddr[C_S_AXI_ADDR_WIDTH-1 -: 2];
    end else begin
      s_axi.arready <= 1'b0;
    end
  end

  // The register array is sampled with non-blocking semantics, so a read
  // committing on the same edge as a write returns the pre-write value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      s_axi.rvalid <= 1'b0;
      s_axi.rdata  <= '0;
    end else if (rd_fire) begin
      s_axi.rvalid <= 1'b1;
      s_axi.rdata  <= regs[ar_idx];
    end else if (s_axi.rvalid && s_axi.rready) begin
      s_axi.rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_slave_mmap_4x32_r4.sv
// tb/tb_axi_lite_slave_mmap_4x32_r4.sv - scoreboard bench for the 4x32 AXI-Lite register slave
module tb_axi_lite_slave_mmap_4x32_r4;
  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  logic [31:0] model [4];
  logic [31:0] exp_q [$];

  axi_lite_slave_mmap_4x32_r4_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  axi_lite_slave_mmap_4x32_r4 #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (resetn),
    .s_axi         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one write; keeps VALIDs up for 'hold' extra cycles and withholds
  // BREADY for 'bdelay' cycles (hold must not exceed bdelay).
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold, input int bdelay);
    bit got;
    got = 1'b0;
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.awready && bus.wready) got = 1'b1;
    end
    check("write_ready_seen", {31'd0, got}, 32'd1);
    tick();
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
    end
    check("bvalid_set", {31'd0, bus.bvalid}, 32'd1);
    check("bresp", {30'd0, bus.bresp}, 32'd0);
    for (int i = 0; i < bdelay; i++) begin
      if (i >= hold) begin
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
      end
      tick();
      check("bvalid_hold", {31'd0, bus.bvalid}, 32'd1);
      check("no_second_aw", {31'd0, bus.awready}, 32'd0);
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    tick();
    bus.bready  = 1'b0;
    check("bvalid_clear", {31'd0, bus.bvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] a, input int hold, input int rdelay);
    bit got;
    logic [31:0] expv;
    got = 1'b0;
    exp_q.push_back(model[a[3:2]]);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.arready) got = 1'b1;
    end
    check("read_ready_seen", {31'd0, got}, 32'd1);
    tick();
    check("rvalid_set", {31'd0, bus.rvalid}, 32'd1);
    expv = exp_q.pop_front();
    check($sformatf("rdata@%h", a), bus.rdata, expv);
    check("rresp", {30'd0, bus.rresp}, 32'd0);
    for (int i = 0; i < rdelay; i++) begin
      if (i >= hold) bus.arvalid = 1'b0;
      tick();
      check("rvalid_hold", {31'd0, bus.rvalid}, 32'd1);
      check("rdata_stable", bus.rdata, expv);
      check("no_second_ar", {31'd0, bus.arready}, 32'd0);
    end
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    tick();
    bus.rready  = 1'b0;
    check("rvalid_clear", {31'd0, bus.rvalid}, 32'd0);
  endtask

  task automatic apply_reset(input int cycles);
    resetn = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    for (int r = 0; r < 4; r++) model[r] = 32'd0;
    check("rst_awready", {31'd0, bus.awready}, 32'd0);
    check("rst_wready",  {31'd0, bus.wready},  32'd0);
    check("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
    check("rst_arready", {31'd0, bus.arready}, 32'd0);
    check("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
    check("rst_rdata",   bus.rdata,            32'd0);
    resetn = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int r = 0; r < 4; r++) model[r] = 32'd0;

    apply_reset(3);
    for (int r = 0; r < 4; r++) do_read(4'(r * 4), 0, 0);

    do_write(4'h0, 32'hDEADBEEF, 4'hF, 0, 0);
    do_write(4'h4, 32'h12345678, 4'hF, 0, 1);
    do_write(4'h8, 32'hABCDEF01, 4'hF, 0, 0);
    do_write(4'hC, 32'h87654321, 4'hF, 0, 2);
    for (int r = 0; r < 4; r++) do_read(4'(r * 4), 0, 0);

    do_write(4'h0, 32'h000000FF, 4'h1, 0, 0);
    do_write(4'h4, 32'hAA000000, 4'h8, 0, 0);
    do_write(4'h8, 32'h0000FFFF, 4'h6, 0, 0);
    for (int r = 0; r < 3; r++) do_read(4'(r * 4), 0, 0);
    check("const_reg0", model[0], 32'hDEADBEFF);
    check("const_reg1", model[1], 32'hAA345678);
    check("const_reg2", model[2], 32'hAB00FF01);

    do_write(4'hF, 32'hFFFFFFFF, 4'hF, 0, 0);
    for (int r = 0; r < 4; r++) do_read(4'(r * 4), 0, 0);
    do_read(4'hE, 0, 0);

    // Master holds VALIDs past READY and stalls the ready signals.
    do_write(4'h4, 32'h0BADF00D, 4'hF, 1, 3);
    do_read(4'h4, 1, 3);
    do_write(4'h8, 32'h55667788, 4'h3, 2, 2);
    do_read(4'h8, 2, 4);

    // Concurrent read and write of the same register: read sees old data.
    fork
      do_write(4'h4, 32'hCAFEBABE, 4'hF, 0, 0);
      do_read(4'h4, 0, 0);
    join
    do_read(4'h4, 0, 0);

    apply_reset(5);
    for (int r = 0; r < 4; r++) do_read(4'(r * 4), 0, 1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
